cond_branch_unit: RTL
=====================

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
 clk  in  1  system clock, all state updates on rising edge
 reset  in  1  asynchronous, active-low reset
 flags_in  in  4  architectural flags from flag register, [3]=N [2]=Z [1]=C [0]=V
 fwd_valid  in  1  a flag-setting instruction writes the flag register this cycle
 fwd_flags  in  4  flag values being written this cycle, same bit order
 set_issue  in  1  a flag-setting instruction entered the pipeline this cycle
 br_valid  in  1  conditional-branch request
 br_cond  in  4  LEGv8 condition code of the request
 flush  in  1  discard any pending or arriving branch request
 br_ready  out  1  block can accept a request
 stall  out  1  branch waiting on in-flight flags
 res_valid  out  1  one-cycle pulse, decision available
 res_taken  out  1  decision, valid only with res_valid
 err  out  1  sticky scoreboard over/underflow

Function
REQ-002 The block SHALL keep a 2-bit in-flight counter cnt (0..3) of flag-setters issued but not yet written.
REQ-003 Each cycle cnt SHALL update: +1 on set_issue only, -1 on fwd_valid only, unchanged when both or neither.
REQ-004 A set_issue at cnt=3 without fwd_valid SHALL leave cnt=3 and set err; fwd_valid at cnt=0 without set_issue SHALL leave cnt=0 and set err.
REQ-005 err SHALL stay 1 until reset.
REQ-006 The FSM SHALL have two states, IDLE and WAIT; br_ready = (state==IDLE); stall = (state==WAIT).
REQ-007 A request is accepted when br_valid && br_ready && !flush; br_cond is captured into cond_q on acceptance.
REQ-008 Flag source for a decision SHALL use registered cnt (pre-update): cnt==0 -> flags_in; cnt==1 && fwd_valid -> fwd_flags; otherwise no decision.
REQ-009 set_issue in the acceptance cycle SHALL belong to a younger instruction and SHALL NOT block that request.
REQ-010 IDLE with accepted request and a flag source available SHALL decide that cycle and remain IDLE; with no source SHALL go to WAIT.
REQ-011 WAIT SHALL re-evaluate each cycle with cond_q per REQ-008; on a source it SHALL decide and go to IDLE.
REQ-012 Decision outputs SHALL be registered: res_valid=1 and res_taken set on the clock edge ending the deciding cycle, res_valid=0 otherwise; latency 1 cycle from deciding cycle.
REQ-013 Back-to-back requests SHALL be accepted every cycle while decisions are immediate.
REQ-014 flush in WAIT SHALL return to IDLE with no res_valid; flush in IDLE SHALL block acceptance; flush SHALL NOT change cnt.
REQ-015 Condition evaluation: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !GT; 1110/1111 AL 1.
REQ-016 AL/1111 SHALL still obey the REQ-008 wait rule (uniform latency).

Reset
REQ-017 While reset=0: state=IDLE, cnt=0, cond_q=0, res_valid=0, res_taken=0, err=0, br_ready=1, stall=0, asynchronously.
REQ-018 Reset asserted in WAIT SHALL drop the pending request with no res_valid after release.

Verification
REQ-019 cnt=0, flags_in=0100, br_valid with br_cond=0000 -> next cycle res_valid=1, res_taken=1; stall never high.
REQ-020 set_issue one cycle, then br_cond=1010 -> stall=1, br_ready=0; two cycles later fwd_valid with fwd_flags=1001 -> next cycle res_valid=1, res_taken=1, stall=0.
REQ-021 cnt=2, br_cond=1100 -> WAIT; fwd_valid (cnt->1), then fwd_valid with fwd_flags=0100 -> res_taken=0 one cycle after second fwd_valid.
REQ-022 In WAIT assert flush -> IDLE next cycle, no res_valid, cnt unchanged; four set_issue with no fwd_valid -> cnt=3, err=1 held until reset.
REQ-023 Three back-to-back requests at cnt=0 (0000, 0001, 1110) with Z=1 -> res_valid three consecutive cycles, res_taken=1,0,1.
REQ-024 Sweep all 16 br_cond x 16 flags_in at cnt=0 -> res_taken matches REQ-015 table.

Source files
------------

// File: rtl/cond_branch_unit.sv
// Conditional-branch resolver: decides LEGv8 conditions against architectural or
// forwarded flags, stalling while older flag-setting instructions are still in flight.
module cond_branch_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flags_in,
  input  logic       fwd_valid,
  input  logic [3:0] fwd_flags,
  input  logic       set_issue,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       flush,
  output logic       br_ready,
  output logic       stall,
  output logic       res_valid,
  output logic       res_taken,
  output logic       err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] cond_q, cond_d;
  logic       res_valid_q, res_valid_d;
  logic       res_taken_q, res_taken_d;
  logic       err_q, err_d;

  logic       src_ok;
  logic [3:0] src_flags;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, gt;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    gt = !z && (n == v);
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = !cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cf && !z;
      4'b1001: cond_eval = !(cf && !z);
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = gt;
      4'b1101: cond_eval = !gt;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Source selection uses the pre-update count, so a same-cycle set_issue is younger.
  assign src_ok    = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && fwd_valid);
  assign src_flags = (cnt_q == 2'd0) ? flags_in : fwd_flags;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (set_issue && !fwd_valid) begin
      if (cnt_q == 2'd3) err_d = 1'b1;
      else               cnt_d = cnt_q + 2'd1;
    end else if (fwd_valid && !set_issue) begin
      if (cnt_q == 2'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    res_valid_d = 1'b0;
    res_taken_d = res_taken_q;
    case (state_q)
      IDLE: begin
        if (br_valid && !flush) begin
          cond_d = br_cond;
          if (src_ok) begin
            res_valid_d = 1'b1;
            res_taken_d = cond_eval(br_cond, src_flags);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (src_ok) begin
          res_valid_d = 1'b1;
          res_taken_d = cond_eval(cond_q, src_flags);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cond_q      <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cond_q      <= cond_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      err_q       <= err_d;
    end
  end

  assign br_ready  = (state_q == IDLE);
  assign stall     = (state_q == WAIT);
  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign err       = err_q;

endmodule
